// File: rtl/mmh_pkg.sv
// Shared constants and state encoding for the MMH-MH product collector.
package mmh_pkg;
  localparam int DATA_W  = 64;
  localparam int LANES   = 16;
  localparam int ACC_W   = 192;
  localparam int MUL_LAT = 2;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int IDX_W   = $clog2(LANES);
  localparam int CNT_W   = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/mmh_mul64_pipe.sv
// Pipelined unsigned DATA_W x DATA_W multiplier carrying a valid bit and lane tag.
module mmh_mul64_pipe
  import mmh_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [IDX_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [PROD_W-1:0] out_prod,
  output logic [IDX_W-1:0]  out_tag,
  output logic              pending
);
  logic [LAT-1:0]    vld_reg;
  logic [PROD_W-1:0] prod_reg [LAT];
  logic [IDX_W-1:0]  tag_reg  [LAT];

  // Only the valid chain is reset; data stages simply follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    prod_reg[0] <= {{DATA_W{1'b0}}, a_data} * {{DATA_W{1'b0}}, b_data};
    tag_reg[0]  <= in_tag;
    for (int i = 1; i < LAT; i++) begin
      prod_reg[i] <= prod_reg[i-1];
      tag_reg[i]  <= tag_reg[i-1];
    end
  end

  assign out_valid = vld_reg[LAT-1];
  assign out_prod  = prod_reg[LAT-1];
  assign out_tag   = tag_reg[LAT-1];

  // Products still travelling behind the output stage.
  generate
    if (LAT > 1) begin : g_pend
      assign pending = |vld_reg[LAT-2:0];
    end else begin : g_nopend
      assign pending = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/mmh_product_collector.sv
// Collects key*seed products into 16 zero-extended lanes and hands a full
// (or in_last-terminated) block to the carry-save sum tree.
module mmh_product_collector
  import mmh_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      key_data,
  input  logic [DATA_W-1:0]      seed_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ACC_W*LANES-1:0] out_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       lane_count
);
  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  lane_cnt_reg;
  logic [ACC_W-1:0]  lane_reg [LANES];

  logic              accept;
  logic              final_accept;
  logic              mul_valid;
  logic              mul_pending;
  logic [PROD_W-1:0] mul_prod;
  logic [IDX_W-1:0]  mul_tag;

  assign accept       = in_valid & in_ready_reg;
  assign final_accept = accept & (in_last | (lane_cnt_reg == CNT_W'(LANES - 1)));

  mmh_mul64_pipe #(.LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a_data    (key_data),
    .b_data    (seed_data),
    .in_tag    (lane_cnt_reg[IDX_W-1:0]),
    .out_valid (mul_valid),
    .out_prod  (mul_prod),
    .out_tag   (mul_tag),
    .pending   (mul_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_FILL;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      lane_cnt_reg  <= '0;
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else begin
      if (mul_valid) lane_reg[mul_tag] <= {{(ACC_W - PROD_W){1'b0}}, mul_prod};
      case (state_reg)
        ST_FILL: begin
          in_ready_reg <= 1'b1;
          if (accept) lane_cnt_reg <= lane_cnt_reg + CNT_W'(1);
          if (final_accept) begin
            state_reg    <= ST_FLUSH;
            in_ready_reg <= 1'b0;
          end
        end
        // The last product sits in the output stage when nothing trails it.
        ST_FLUSH: begin
          if (!mul_pending) begin
            state_reg     <= ST_HOLD;
            out_valid_reg <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_reg     <= ST_FILL;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            lane_cnt_reg  <= '0;
            for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
      assign out_bus[gi*ACC_W +: ACC_W] = lane_reg[gi];
    end
  endgenerate

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign lane_count = lane_cnt_reg;
endmodule

// File: tb/tb_mmh_product_collector.sv
// Scoreboard bench for mmh_product_collector: expected blocks are queued as
// pairs are driven and compared when the collector presents a block.
module tb_mmh_product_collector;
  import mmh_pkg::*;

  localparam int BUS_W = ACC_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] key_data, seed_data;
  logic              in_valid, in_last, in_ready;
  logic [BUS_W-1:0]  out_bus;
  logic              out_valid, out_ready;
  logic [CNT_W-1:0]  lane_count;

  always #5 clk = ~clk;

  mmh_product_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_data   (key_data),
    .seed_data  (seed_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_bus    (out_bus),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lane_count (lane_count)
  );

  typedef struct {
    logic [BUS_W-1:0] bus;
    logic [CNT_W-1:0] cnt;
  } blk_t;

  blk_t              exp_q[$];
  logic [DATA_W-1:0] key_arr  [LANES];
  logic [DATA_W-1:0] seed_arr [LANES];
  int                cyc = 0;
  int                last_acc_cyc = 0;
  int                tests_run = 0;
  int                tests_failed = 0;
  logic [BUS_W-1:0]  ref_bus, got_bus;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive n pairs from key_arr/seed_arr; optionally queue the expected block.
  task automatic drive_pairs(input int n, input bit gaps, input int last_at, input bit push);
    blk_t b;
    b.bus = '0;
    b.cnt = CNT_W'(n);
    for (int i = 0; i < n; i++) begin
      logic [2*DATA_W-1:0] p;
      p = {{DATA_W{1'b0}}, key_arr[i]} * {{DATA_W{1'b0}}, seed_arr[i]};
      b.bus[i*ACC_W +: ACC_W] = {{(ACC_W - 2*DATA_W){1'b0}}, p};
    end
    if (push) exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      int w;
      if (gaps) begin
        while ($urandom_range(1, 0) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      key_data  = key_arr[i];
      seed_data = seed_arr[i];
      in_last   = (i == last_at);
      in_valid  = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
        $display("FAIL accept_timeout pair %0d: in_ready=%b required 1", i, in_ready);
        tests_failed++;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a block, pop the scoreboard, optionally stall, then hand it off.
  task automatic collect_block(input string name, input int hold, output logic [BUS_W-1:0] bus);
    blk_t             e;
    bit               ready_ok = 1'b1;
    bit               stable_ok = 1'b1;
    int               w = 0;
    logic [BUS_W-1:0] snap;
    logic [CNT_W-1:0] snapc;
    bus = '0;
    out_ready = 1'b0;
    while (!out_valid && w < 40) begin
      if (in_ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clk); #1;
      w++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s out_valid_timeout: out_valid=%b required 1", name, out_valid);
      tests_failed++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    tests_run++;
    if (ready_ok !== 1'b1) begin
      $display("FAIL %s in_ready_flush: in_ready=1 seen during flush, required 0", name);
      tests_failed++;
    end
    tests_run++;
    if (cyc - last_acc_cyc != MUL_LAT) begin
      $display("FAIL %s latency: out_valid %0d edges after last accept, required %0d",
               name, cyc - last_acc_cyc, MUL_LAT);
      tests_failed++;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard_empty: got a block, required none", name);
      tests_failed++;
    end else begin
      e = exp_q.pop_front();
      if (lane_count !== e.cnt) begin
        $display("FAIL %s lane_count: got %0d required %0d", name, lane_count, e.cnt);
        tests_failed++;
      end
      tests_run++;
      if (out_bus !== e.bus) begin
        int l = 0;
        for (int k = LANES - 1; k >= 0; k--)
          if (out_bus[k*ACC_W +: ACC_W] !== e.bus[k*ACC_W +: ACC_W]) l = k;
        $display("FAIL %s out_bus lane %0d: got %h required %h", name, l,
                 out_bus[l*ACC_W +: ACC_W], e.bus[l*ACC_W +: ACC_W]);
        tests_failed++;
      end
    end
    snap  = out_bus;
    snapc = lane_count;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (out_bus !== snap || lane_count !== snapc || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    if (hold > 0) begin
      tests_run++;
      if (stable_ok !== 1'b1) begin
        $display("FAIL %s hold_stable: outputs changed during %0d stall cycles, required stable",
                 name, hold);
        tests_failed++;
      end
    end
    bus = snap;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      tests_failed++;
    end
    tests_run++;
    if (out_bus !== '0 || lane_count !== '0) begin
      $display("FAIL %s cleared: lane0=%h lane_count=%0d required 0/0", name,
               out_bus[ACC_W-1:0], lane_count);
      tests_failed++;
    end
    $display("[TB] block %s lanes=%0d collected", name, snapc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    key_data = '0; seed_data = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
      tests_failed++;
    end
    tests_run++;
    if (lane_count !== '0 || out_bus !== '0) begin
      $display("FAIL reset_data: lane_count=%0d lane0=%h required 0/0", lane_count, out_bus[ACC_W-1:0]);
      tests_failed++;
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_release: in_ready=%b before first clock, required 0", in_ready);
      tests_failed++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_ready: in_ready=%b after first clock, required 1", in_ready);
      tests_failed++;
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = DATA_W'(i + 1);
      seed_arr[i] = DATA_W'(2);
    end
    drive_pairs(LANES, 1'b0, -1, 1'b1);
    collect_block("back_to_back", 0, ref_bus);
  endtask

  task automatic test_all_ones();
    logic [ACC_W-1:0] want;
    want = {64'h0000000000000000, 64'hFFFFFFFFFFFFFFFE, 64'h0000000000000001};
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = '1;
      seed_arr[i] = '1;
    end
    drive_pairs(LANES, 1'b0, LANES - 1, 1'b1);
    collect_block("all_ones_last15", 0, got_bus);
    tests_run++;
    if (got_bus[7*ACC_W +: ACC_W] !== want) begin
      $display("FAIL all_ones_lane7: got %h required %h", got_bus[7*ACC_W +: ACC_W], want);
      tests_failed++;
    end
  endtask

  task automatic test_short_block_hold();
    in_last = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_last = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin
      $display("FAIL last_without_valid: in_ready=%b required 1", in_ready);
      tests_failed++;
    end
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = DATA_W'(3);
      seed_arr[i] = DATA_W'(5);
    end
    drive_pairs(5, 1'b0, 4, 1'b1);
    collect_block("short5_hold10", 10, got_bus);
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = 64'hAAAA_5555_0F0F_F0F0 ^ DATA_W'(i);
      seed_arr[i] = 64'h1234_5678_9ABC_DEF0;
    end
    drive_pairs(7, 1'b0, -1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_bus !== '0) begin
      $display("FAIL midreset_state: out_valid=%b in_ready=%b lane0=%h required 0/0/0",
               out_valid, in_ready, out_bus[ACC_W-1:0]);
      tests_failed++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out_bus !== '0) quiet = 1'b0;
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      $display("FAIL midreset_quiet: output appeared for aborted block, required none");
      tests_failed++;
    end
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = DATA_W'(1);
      seed_arr[i] = DATA_W'(i);
    end
    drive_pairs(LANES, 1'b0, -1, 1'b1);
    collect_block("after_midreset", 0, got_bus);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < LANES; i++) begin
      key_arr[i]  = DATA_W'(i + 1);
      seed_arr[i] = DATA_W'(2);
    end
    out_ready = 1'b1;
    drive_pairs(LANES, 1'b1, -1, 1'b1);
    collect_block("gaps", 2, got_bus);
    tests_run++;
    if (got_bus !== ref_bus) begin
      $display("FAIL gaps_vs_b2b: lane15 got %h required %h",
               got_bus[15*ACC_W +: ACC_W], ref_bus[15*ACC_W +: ACC_W]);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_all_ones();
    test_short_block_hold();
    test_reset_mid();
    test_gaps();
    tests_run++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: %0d blocks pending, required 0", exp_q.size());
      tests_failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
